serial_alu_seq: RTL

Bit-serial ALU sequencer. It drives a single one-bit ALU slice through a full-width operation, one bit per clock, from LSB to MSB. The sequencer feeds each cycle's carry back into the next cycle and assembles the word result. It sits between the execute-stage control and one `bitALU` slice, in area-reduced configurations of the pipelined CPU, and issues the same 3-bit `Signal` operation codes the slice decodes.

---
 rtl/serial_alu_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_seq
// Brief    : Bit-serial ALU sequencer. Walks one external 1-bit ALU slice
//            through a WIDTH-bit AND/OR/ADD/SUB/SLT operation, LSB first,
//            one bit per clock, chaining the slice carry between cycles.
// Options  : SERIAL_ALU_OVF_EN - build signed-overflow detection for ADD/SUB
//            (otherwise `overflow` is tied low).
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             bad_op,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_signal,
    output logic             slice_carryin,
    output logic             slice_less,
    input  logic             slice_out,
    input  logic             slice_carryout,
    input  logic             slice_set
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       op_q,     op_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             bad_op_q, bad_op_d;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    function automatic logic op_valid(input logic [2:0] o);
        return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) ||
               (o == OP_SUB) || (o == OP_SLT);
    endfunction

    // State register; synchronous reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            bad_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            bad_op_q <= bad_op_d;
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    // Overflow flag register, held alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    // Next-state logic and slice drive.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        carry_d       = carry_q;
        result_d      = result_q;
        zero_d        = zero_q;
        bad_op_d      = bad_op_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d         = ovf_q;
`endif
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_signal  = 3'b000;
        slice_carryin = 1'b0;
        slice_less    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
                    zero_d   = 1'b1;
`ifdef SERIAL_ALU_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    if (op_valid(op)) begin
                        bad_op_d = 1'b0;
                        state_d  = RUN;
                    end else begin
                        // Unknown code: report it and finish with a zero result.
                        bad_op_d = 1'b1;
                        state_d  = FINISH;
                    end
                end
            end

            RUN: begin
                slice_a       = a_q[idx_q];
                slice_b       = b_q[idx_q];
                slice_signal  = op_q;
                // Bit 0 gets the subtract carry-in (op[2]); later bits ripple.
                slice_carryin = (idx_q == '0) ? op_q[2] : carry_q;

                result_d[idx_q] = slice_out;
                carry_d         = slice_carryout;
                idx_d           = idx_q + 1'b1;

                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                    // The MSB slice's Set (sign of a-b) is folded into the
                    // result on this edge so result/zero are valid with done.
                    if (op_q == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, slice_set};
                    end
                    zero_d = (result_d == '0);
`ifdef SERIAL_ALU_OVF_EN
                    // Carry into the MSB is the slice carry-in this cycle.
                    if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                        ovf_d = slice_carryin ^ slice_carryout;
                    end else begin
                        ovf_d = 1'b0;
                    end
`endif
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mapping.
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH);
    assign result = result_q;
    assign zero   = zero_q;
    assign bad_op = bad_op_q;
`ifdef SERIAL_ALU_OVF_EN
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire
